inv_key_expand: RTL

INV_KEY_EXPAND -- requirements
Module: inv_key_expand

---
 rtl/inv_key_expand_pkg.sv | 25 ++
 rtl/inv_key_expand_if.sv | 24 ++
 rtl/aes_sbox.sv | 31 +++
 rtl/inv_key_expand.sv | 105 ++++++++++
 4 files changed

// File: rtl/inv_key_expand_pkg.sv
// Shared AES constants for the inverse AES-128 key schedule: widths, round
// constants and the controller state encoding.
package inv_key_expand_pkg;

  localparam int BYTE   = 8;
  localparam int DWORD  = 32;
  localparam int LENGTH = 128;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Round constant as a full word; indices past the table yield zero.
  function automatic logic [31:0] rcon_word(input logic [3:0] i);
    if (i < 4'd10) return {RCON[i], 24'h000000};
    return 32'h00000000;
  endfunction

endpackage

// File: rtl/inv_key_expand_if.sv
// Request/stream bundle between the key source/consumer and inv_key_expand.
interface inv_key_expand_if;
  import inv_key_expand_pkg::*;

  logic              start;
  logic [LENGTH-1:0] key_in;
  logic              out_ready;
  logic              out_valid;
  logic [LENGTH-1:0] round_key;
  logic [3:0]        rnd_out;
  logic              busy;
  logic              done;

  modport master (
    output start, key_in, out_ready,
    input  out_valid, round_key, rnd_out, busy, done
  );

  modport slave (
    input  start, key_in, out_ready,
    output out_valid, round_key, rnd_out, busy, done
  );

endinterface

// File: rtl/aes_sbox.sv
// AES forward S-box, purely combinational table lookup.
module aes_sbox
  import inv_key_expand_pkg::*;
(
  input  logic [BYTE-1:0] a,
  output logic [BYTE-1:0] y
);

  // Entry 0x00 sits in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[(255 - int'(a)) * 8 +: 8];

endmodule

// File: rtl/inv_key_expand.sv
// Walks the AES-128 key schedule backwards from the round-10 key to the
// cipher key, streaming one round key per accepted handshake.
module inv_key_expand #(
  parameter int BYTE   = inv_key_expand_pkg::BYTE,
  parameter int DWORD  = inv_key_expand_pkg::DWORD,
  parameter int LENGTH = inv_key_expand_pkg::LENGTH
) (
  input  logic            clk,
  input  logic            rst,
  inv_key_expand_if.slave bus
);
  import inv_key_expand_pkg::*;

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last round key
  // RUN   | round_key valid, stepping down on each accepted key

  state_t            state, state_nx;
  logic [LENGTH-1:0] key_q, key_nx, key_step;
  logic [3:0]        rnd_q, rnd_nx;
  logic              valid_q, valid_nx;
  logic              busy_q, busy_nx;
  logic              done_q, done_nx;

  logic [DWORD-1:0]  w0, w1, w2, w3;
  logic [DWORD-1:0]  p0, p1, p2, p3;
  logic [DWORD-1:0]  rot, sub;

  assign {w0, w1, w2, w3} = key_q;

  assign p3  = w3 ^ w2;
  assign p2  = w2 ^ w1;
  assign p1  = w1 ^ w0;
  assign rot = {p3[DWORD-BYTE-1:0], p3[DWORD-1:DWORD-BYTE]};

  for (genvar g = 0; g < DWORD / BYTE; g++) begin : g_sub
    aes_sbox u_sbox (
      .a (rot[g*BYTE +: BYTE]),
      .y (sub[g*BYTE +: BYTE])
    );
  end

  // Round r recovers the first word of r-1 with RCON(r-1).
  assign p0       = w0 ^ sub ^ rcon_word(rnd_q - 4'd1);
  assign key_step = {p0, p1, p2, p3};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key_q   <= '0;
      rnd_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      key_q   <= key_nx;
      rnd_q   <= rnd_nx;
      valid_q <= valid_nx;
      busy_q  <= busy_nx;
      done_q  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    key_nx   = key_q;
    rnd_nx   = rnd_q;
    valid_nx = valid_q;
    busy_nx  = busy_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = RUN;
          key_nx   = bus.key_in;
          rnd_nx   = 4'd10;
          valid_nx = 1'b1;
          busy_nx  = 1'b1;
        end
      end
      RUN: begin
        if (valid_q && bus.out_ready) begin
          if (rnd_q == 4'd0) begin
            state_nx = IDLE;
            valid_nx = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
          end else begin
            key_nx = key_step;
            rnd_nx = rnd_q - 4'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.out_valid = valid_q;
  assign bus.round_key = key_q;
  assign bus.rnd_out   = rnd_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
